// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and
// instruction memory. The fetch stage is the master side.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_instr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_instr
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps a single instruction-memory request outstanding, captures the returned
// word together with its PC and hands it to the decoder. A decode stall holds
// the IF/ID register and pauses fetching; a redirect from EX squashes the
// in-flight fetch and restarts at the target address.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc
);

  // REQ : presenting a request for pc
  // WAIT: request accepted, response owed
  // BUF : response captured while stalled, waiting for stall to drop
  // DROP: response owed for a squashed fetch, to be discarded
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_BUF  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;           // next address to fetch
  logic [31:0] inflight_pc;  // address of the outstanding / buffered fetch
  logic [31:0] buf_instr;    // word returned during a stall

  logic        req_fire;
  logic [31:0] redirect_target;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // A request is presented only from REQ, and is suppressed during reset,
  // while decode is stalled, and in the cycle a redirect arrives. The address
  // is the registered pc, so it stays stable for as long as ready is low.
  assign imem.imem_req_valid = (state == S_REQ) && !reset && !stall && !redirect_valid;
  assign imem.imem_req_addr  = pc;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

  // Fetch FSM, PC, response buffer and IF/ID register.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      // NOTE: the buffer is reset too; it is a single register, not a memory
      // array, and clearing it keeps a stale word from ever reaching decode.
      buf_instr   <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (redirect_valid) begin
      // Redirect beats stall: squash everything and restart at the target.
      pc          <= redirect_target;
      buf_instr   <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      unique case (state)
        // A response still owed must be swallowed unless it lands right now.
        S_WAIT, S_DROP: state <= imem.imem_resp_valid ? S_REQ : S_DROP;
        default:        state <= S_REQ;
      endcase
    end else begin
      // Unstalled cycles load a bubble unless a word is delivered below;
      // the PC field keeps its old value for bubbles.
      if (!stall) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end

      unique case (state)
        S_REQ: begin
          // Responses seen here are protocol errors and are ignored.
          if (req_fire) begin
            inflight_pc <= pc;
            pc          <= pc + 32'd4;
            state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            if (!stall) begin
              if_id_valid <= 1'b1;
              if_id_instr <= imem.imem_resp_instr;
              if_id_pc    <= inflight_pc;
              state       <= S_REQ;
            end else begin
              buf_instr   <= imem.imem_resp_instr;
              state       <= S_BUF;
            end
          end
        end

        S_BUF: begin
          if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_instr <= buf_instr;
            if_id_pc    <= inflight_pc;
            buf_instr   <= NOP_INSTR;
            state       <= S_REQ;
          end
        end

        S_DROP: begin
          if (imem.imem_resp_valid) begin
            state <= S_REQ;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A transaction-level model (one outstanding
// fetch, optional held word) predicts the outputs every cycle; literal checks
// in the stimulus pin the model to hand-computed values.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (bus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owed: a fetch has been accepted and its response has not come back
  // dead: that owed response belongs to a squashed fetch
  // held: a returned word is parked because decode was stalled
  logic        m_owed, m_dead, m_held;
  logic [31:0] m_held_w, m_pc, m_fpc;
  logic        e_valid;
  logic [31:0] e_instr, e_pc;

  always @(posedge clk) begin : model
    logic        got;
    logic [31:0] w;
    got = 1'b0;
    w   = NOP;
    if (reset) begin
      m_owed <= 1'b0; m_dead <= 1'b0; m_held <= 1'b0;
      m_pc   <= 32'h0000_1000;
      e_valid <= 1'b0; e_instr <= NOP; e_pc <= '0;
    end else if (redirect_valid) begin
      m_owed  <= m_owed && !bus.imem_resp_valid;
      m_dead  <= m_owed && !bus.imem_resp_valid;
      m_held  <= 1'b0;
      m_pc    <= redirect_pc & 32'hFFFF_FFFC;
      e_valid <= 1'b0;
      e_instr <= NOP;
    end else begin
      if (m_owed && bus.imem_resp_valid) begin
        m_owed <= 1'b0;
        m_dead <= 1'b0;
        if (!m_dead) begin
          if (stall) begin
            m_held   <= 1'b1;
            m_held_w <= bus.imem_resp_instr;
          end else begin
            got = 1'b1;
            w   = bus.imem_resp_instr;
          end
        end
      end else if (m_held && !stall) begin
        got    = 1'b1;
        w      = m_held_w;
        m_held <= 1'b0;
      end else if (!m_owed && !m_held && !stall && bus.imem_req_ready) begin
        m_owed <= 1'b1;
        m_dead <= 1'b0;
        m_fpc  <= m_pc;
        m_pc   <= m_pc + 32'd4;
      end
      if (!stall) begin
        e_valid <= got;
        e_instr <= got ? w : NOP;
        if (got) e_pc <= m_fpc;
      end
    end
  end

  // Compare process: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_req;
      exp_req = !reset && !m_owed && !m_held && !stall && !redirect_valid;
      check("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_req});
      if (exp_req) check("req_addr", bus.imem_req_addr, m_pc);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
      check("if_id_instr", if_id_instr, e_instr);
      if (e_valid) check("if_id_pc", if_id_pc, e_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic rdy, input logic rv, input logic [31:0] ri,
                     input logic st, input logic rd, input logic [31:0] rp);
    bus.imem_req_ready  = rdy;
    bus.imem_resp_valid = rv;
    bus.imem_resp_instr = ri;
    stall               = st;
    redirect_valid      = rd;
    redirect_pc         = rp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p);
    check({tag, " v"}, {31'd0, if_id_valid}, {31'd0, v});
    check({tag, " instr"}, if_id_instr, i);
    check({tag, " pc"}, if_id_pc, p);
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, '0, 0, 0, '0);
    tick();
    chk_en = 1'b1;
    chk_ifid("reset", 0, NOP, 32'h0);
    check("reset req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    tick(); tick();
    reset = 1'b0;

    // 1: first fetch at RESET_PC, response next cycle
    drv(1, 0, '0, 0, 0, '0); #2;
    check("t1 req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("t1 addr", bus.imem_req_addr, 32'h0000_1000);
    tick();
    drv(0, 1, 32'h0050_0093, 0, 0, '0); tick();

    // 2: ready low for three cycles, address must hold
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, '0, 0, 0, '0); #2;
      if (i == 0) chk_ifid("t1 ifid", 1, 32'h0050_0093, 32'h0000_1000);
      check("t2 req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      check("t2 addr", bus.imem_req_addr, 32'h0000_1004);
      tick();
    end
    drv(1, 0, '0, 0, 0, '0); tick();

    // 3: response arrives while stalled
    drv(0, 1, 32'h0020_81B3, 1, 0, '0); tick();
    drv(0, 0, '0, 1, 0, '0); #2;
    check("t3 no req", {31'd0, bus.imem_req_valid}, 32'd0);
    chk_ifid("t3 frozen", 0, NOP, 32'h0000_1000);
    tick();
    drv(0, 0, '0, 0, 0, '0); tick();
    drv(1, 0, '0, 0, 0, '0); #2;
    chk_ifid("t3 ifid", 1, 32'h0020_81B3, 32'h0000_1004);
    check("t3 addr", bus.imem_req_addr, 32'h0000_1008);
    tick();

    // 4: redirect while waiting on 0x1008, late response dropped
    drv(0, 0, '0, 0, 1, 32'h0000_2000); #2;
    check("t4 redir no req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    drv(0, 1, 32'hDEAD_BEEF, 0, 0, '0); #2;
    check("t4 bubble v", {31'd0, if_id_valid}, 32'd0);
    check("t4 bubble instr", if_id_instr, NOP);
    check("t4 drop no req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    drv(0, 0, '0, 0, 1, 32'h0000_2003); tick();
    drv(1, 0, '0, 0, 0, '0); #2;
    check("t4 addr", bus.imem_req_addr, 32'h0000_2000);
    check("t4 req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    tick();
    drv(0, 1, 32'h0000_0513, 0, 0, '0); tick();

    // 5: redirect and stall together
    drv(1, 0, '0, 1, 1, 32'h0000_3000); #2;
    chk_ifid("t5 before", 1, 32'h0000_0513, 32'h0000_2000);
    tick();
    drv(1, 0, '0, 0, 0, '0); #2;
    chk_ifid("t5 bubble", 0, NOP, 32'h0000_2000);
    check("t5 addr", bus.imem_req_addr, 32'h0000_3000);
    tick();

    // 6: reset while waiting, stale response after release ignored
    reset = 1'b1;
    drv(0, 0, '0, 0, 0, '0); tick();
    reset = 1'b0;
    drv(0, 1, 32'h7777_7777, 0, 0, '0); #2;
    check("t6 addr", bus.imem_req_addr, 32'h0000_1000);
    tick();
    drv(1, 0, '0, 0, 0, '0); #2;
    check("t6 v", {31'd0, if_id_valid}, 32'd0);
    tick();
    drv(0, 1, 32'hAAAA_0001, 0, 0, '0); tick();

    // PC wrap and two-cycle memory latency
    drv(0, 0, '0, 0, 1, 32'hFFFF_FFFE); #2;
    chk_ifid("t6 ifid", 1, 32'hAAAA_0001, 32'h0000_1000);
    tick();
    drv(1, 0, '0, 0, 0, '0); #2;
    check("wrap addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    drv(0, 0, '0, 0, 0, '0); tick();
    drv(0, 1, 32'h1234_5678, 0, 0, '0); #2;
    check("k2 wait v", {31'd0, if_id_valid}, 32'd0);
    tick();
    drv(0, 0, '0, 0, 0, '0); #2;
    chk_ifid("k2 ifid", 1, 32'h1234_5678, 32'hFFFF_FFFC);
    check("wrap next", bus.imem_req_addr, 32'h0000_0000);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
